aes_kat_runner: RTL and testbench

- Parametrised known-answer-test sequencer for the AES-128 core (main_aes).
- Holds NUM_VEC triplets (plaintext, key, expected ciphertext) and replays them into the core one at a time.
- Compares each result against its expected ciphertext, with a per-vector timeout.
- Reports pass/fail counts and the index of the first failure.
- Replaces hand-driven stimulus with a self-checking block usable both in simulation and on silicon bring-up.

---
 rtl/aes_kat_runner.sv | 154 +++++++++++++++
 tb/tb_aes_kat_runner.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/aes_kat_runner.sv
// Known-answer-test sequencer for the AES-128 core: replays stored (plaintext, key, expected)
// triplets into the core and tallies matches, mismatches and timeouts.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start after reset; vector memory writable
// S_LAUNCH | load core inputs from mem[index], pulse dut_start
// S_WAIT   | wait for dut_done or timer terminal count
// S_CHECK  | compare captured ciphertext, update counts, advance index
// S_DONE   | results held until next start; vector memory writable
module aes_kat_runner #(
   parameter int NUM_VEC = 4,
   parameter int AW      = 2,
   parameter int BLK_W   = 128,
   parameter int TIMEOUT = 32,
   parameter int TO_W    = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             load_we,
   input  logic [1:0]       load_sel,
   input  logic [AW-1:0]    load_addr,
   input  logic [BLK_W-1:0] load_data,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [AW:0]      pass_count,
   output logic [AW:0]      fail_count,
   output logic             first_fail_valid,
   output logic [AW-1:0]    first_fail_idx,
   output logic             dut_en,
   output logic             dut_start,
   output logic [BLK_W-1:0] dut_data_in,
   output logic [BLK_W-1:0] dut_key_in,
   input  logic [BLK_W-1:0] dut_data_out,
   input  logic             dut_done
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LAUNCH = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_CHECK  = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam logic [AW:0]     NV_C     = NUM_VEC[AW:0];
   localparam logic [AW-1:0]   LAST_IDX = AW'(NUM_VEC - 1);
   localparam logic [AW-1:0]   ONE_I    = AW'(1);
   localparam logic [AW:0]     ONE_C    = (AW+1)'(1);
   localparam logic [TO_W-1:0] ONE_T    = TO_W'(1);
   localparam logic [TO_W-1:0] TC_T     = TO_W'(TIMEOUT - 1);

   logic [2:0]       state;
   logic [AW-1:0]    index;
   logic [TO_W-1:0]  timer;
   logic             timed_out;
   logic [BLK_W-1:0] captured;
   logic             match;
   logic             addr_ok;

   logic [BLK_W-1:0] mem_pt  [NUM_VEC];
   logic [BLK_W-1:0] mem_key [NUM_VEC];
   logic [BLK_W-1:0] mem_exp [NUM_VEC];

   assign addr_ok   = {1'b0, load_addr} < NV_C;
   assign match     = !timed_out && (captured == mem_exp[index]);
   assign pass      = done && (fail_count == '0);
   assign dut_en    = busy;
   assign dut_start = (state == S_LAUNCH);

   // Vector memory survives reset so a run can be repeated after an abort.
   always_ff @(posedge clk) begin
      if (load_we && !busy && addr_ok) begin
         case (load_sel)
            2'd0:    mem_pt[load_addr]  <= load_data;
            2'd1:    mem_key[load_addr] <= load_data;
            2'd2:    mem_exp[load_addr] <= load_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= S_IDLE;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass_count       <= '0;
         fail_count       <= '0;
         first_fail_valid <= 1'b0;
         first_fail_idx   <= '0;
         index            <= '0;
         timer            <= '0;
         timed_out        <= 1'b0;
         captured         <= '0;
         dut_data_in      <= '0;
         dut_key_in       <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state            <= S_LAUNCH;
                  busy             <= 1'b1;
                  done             <= 1'b0;
                  index            <= '0;
                  pass_count       <= '0;
                  fail_count       <= '0;
                  first_fail_valid <= 1'b0;
                  first_fail_idx   <= '0;
               end
            end
            S_LAUNCH: begin
               dut_data_in <= mem_pt[index];
               dut_key_in  <= mem_key[index];
               timer       <= '0;
               state       <= S_WAIT;
            end
            S_WAIT: begin
               timer <= timer + ONE_T;
               // dut_done takes priority over a coincident terminal count.
               if (dut_done) begin
                  captured  <= dut_data_out;
                  timed_out <= 1'b0;
                  state     <= S_CHECK;
               end else if (timer == TC_T) begin
                  timed_out <= 1'b1;
                  state     <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (match) begin
                  pass_count <= pass_count + ONE_C;
               end else begin
                  fail_count <= fail_count + ONE_C;
                  if (!first_fail_valid) begin
                     first_fail_valid <= 1'b1;
                     first_fail_idx   <= index;
                  end
               end
               if (index == LAST_IDX) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  index <= index + ONE_I;
                  state <= S_LAUNCH;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_kat_runner.sv
// Directed bench for aes_kat_runner with a behavioural AES core stand-in whose
// response delay per vector is programmable.
module tb_aes_kat_runner;

   localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         load_we = 1'b0;
   logic [1:0]   load_sel = 2'd0;
   logic [1:0]   load_addr = 2'd0;
   logic [127:0] load_data = '0;
   logic         busy, done, pass, first_fail_valid, dut_en, dut_start, dut_done;
   logic [2:0]   pass_count, fail_count;
   logic [1:0]   first_fail_idx;
   logic [127:0] dut_data_in, dut_key_in, dut_data_out;

   int n_chk = 0;
   int n_fail = 0;

   aes_kat_runner dut (
      .clk(clk), .reset(reset), .start(start), .load_we(load_we), .load_sel(load_sel),
      .load_addr(load_addr), .load_data(load_data), .busy(busy), .done(done), .pass(pass),
      .pass_count(pass_count), .fail_count(fail_count), .first_fail_valid(first_fail_valid),
      .first_fail_idx(first_fail_idx), .dut_en(dut_en), .dut_start(dut_start),
      .dut_data_in(dut_data_in), .dut_key_in(dut_key_in), .dut_data_out(dut_data_out),
      .dut_done(dut_done)
   );

   always #5 clk = ~clk;

   // Core stand-in: counts WAIT cycles from 1 after the dut_start cycle; delay 0 = never answers.
   int   delays [4] = '{11, 11, 11, 11};
   bit   launch_done [4] = '{0, 0, 0, 0};
   logic [7:0] cnt = '0;
   int   vidx = 0;
   int   cur_vec = 0;
   int   cyc = 0;
   int   st_cyc [4] = '{0, 0, 0, 0};
   int   wide_err = 0;
   logic prev_start = 1'b0;

   always @(posedge clk) begin
      cyc        <= cyc + 1;
      prev_start <= dut_start;
      if (dut_start && prev_start) wide_err <= wide_err + 1;
      if (dut_start) begin
         cnt     <= 8'd1;
         cur_vec <= vidx;
         if (vidx < 4) st_cyc[vidx] <= cyc;
         vidx    <= vidx + 1;
      end else begin
         if (cnt != 0 && cnt != 8'hff) cnt <= cnt + 8'd1;
         if (start && !busy) vidx <= 0;
      end
   end

   assign dut_done = (cnt != 0 && int'(cnt) == delays[cur_vec]) ||
                     (dut_start && vidx < 4 && launch_done[vidx]);
   assign dut_data_out = (dut_data_in == PT && dut_key_in == KEY) ? CT : '0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_mem(input logic [1:0] sel, input logic [1:0] addr, input logic [127:0] data);
      load_we = 1'b1; load_sel = sel; load_addr = addr; load_data = data;
      tick();
      load_we = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 2000) begin
         tick();
         n++;
      end
      if (n >= 2000) chk("done_bound", n, 0);
   endtask

   task automatic run(output int n);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(n);
   endtask

   initial begin
      int n;
      int g;
      repeat (2) tick();
      reset = 1'b0;
      chk("rst_flags", {busy, done, pass, first_fail_valid, dut_start, dut_en}, 6'b0);
      chk("rst_counts", {pass_count, fail_count, first_fail_idx}, 8'h0);
      chk("rst_data_in", dut_data_in, 128'h0);
      chk("rst_key_in", dut_key_in, 128'h0);

      for (int i = 0; i < 4; i++) begin
         write_mem(2'd0, 2'(i), PT);
         write_mem(2'd1, 2'(i), KEY);
         write_mem(2'd2, 2'(i), CT);
      end

      // Nominal run: 4 vectors x 13 cycles
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("a_busy_after_start", {busy, done}, 2'b10);
      wait_done(n);
      chk("a_duration", n, 52);
      chk("a_pass", pass, 1'b1);
      chk("a_pass_count", pass_count, 3'd4);
      chk("a_fail_count", fail_count, 3'd0);
      chk("a_ffv", first_fail_valid, 1'b0);
      chk("a_launches", vidx, 4);
      chk("a_start_width", wide_err, 0);
      chk("a_vec_period", st_cyc[1] - st_cyc[0], 13);
      chk("a_busy_done", {busy, dut_en}, 2'b00);

      // Corrupted expected value for vector 2
      write_mem(2'd2, 2'd2, CT ^ 128'h1);
      run(n);
      chk("b_counts", {pass_count, fail_count}, {3'd3, 3'd1});
      chk("b_first_fail", {first_fail_valid, first_fail_idx}, {1'b1, 2'd2});
      chk("b_pass", pass, 1'b0);
      write_mem(2'd2, 2'd2, CT);

      // Vector 1 never answers: 32 WAIT cycles then the run continues
      delays = '{11, 0, 11, 11};
      run(n);
      chk("c_counts", {pass_count, fail_count}, {3'd3, 3'd1});
      chk("c_first_fail", {first_fail_valid, first_fail_idx}, {1'b1, 2'd1});
      chk("c_timeout_period", st_cyc[2] - st_cyc[1], 34);
      chk("c_next_period", st_cyc[3] - st_cyc[2], 13);

      // Answer on the last WAIT cycle passes; answer only in LAUNCH is ignored
      delays = '{11, 32, 11, 0};
      launch_done[3] = 1'b1;
      run(n);
      chk("d_counts", {pass_count, fail_count}, {3'd3, 3'd1});
      chk("d_first_fail", {first_fail_valid, first_fail_idx}, {1'b1, 2'd3});
      chk("d_edge_period", st_cyc[2] - st_cyc[1], 34);
      delays = '{11, 11, 11, 11};
      launch_done[3] = 1'b0;

      // Reset during WAIT of vector 2, then rerun from intact memory
      start = 1'b1;
      tick();
      start = 1'b0;
      g = 0;
      while (vidx < 3 && g < 200) begin tick(); g++; end
      chk("e_reached_vec2", vidx, 3);
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("e_rst_flags", {busy, done, pass, first_fail_valid, dut_start, dut_en}, 6'b0);
      chk("e_rst_counts", {pass_count, fail_count, first_fail_idx}, 8'h0);
      chk("e_rst_data", {dut_data_in, dut_key_in}, 256'h0);
      run(n);
      chk("e_rerun", {pass, pass_count, fail_count}, {1'b1, 3'd4, 3'd0});

      // Writes and start while busy have no effect
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      load_we = 1'b1; load_sel = 2'd2; load_addr = 2'd0; load_data = '0;
      start = 1'b1;
      tick();
      load_we = 1'b0; start = 1'b0;
      write_mem(2'd0, 2'd1, '0);
      wait_done(n);
      chk("f_busy_run", {pass, pass_count, fail_count}, {1'b1, 3'd4, 3'd0});
      chk("f_duration", n + 7, 52);

      // Reserved select is ignored; start from DONE repeats identically
      write_mem(2'd3, 2'd0, '0);
      run(n);
      chk("g_rerun", {pass, pass_count, fail_count, first_fail_valid}, {1'b1, 3'd4, 3'd0, 1'b0});
      chk("g_duration", n, 52);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
